// File: rtl/permutation_inverse_pkg.sv
// rtl/permutation_inverse_pkg.sv - shared FSM encoding, round limit and lane-index helpers
package permutation_inverse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int MAX_ROUNDS = 24;
    localparam int GRID       = 5;
    localparam int LANES      = GRID * GRID;

    // Flat bit index of lane (x,y) in the state vector.
    function automatic int lane_idx(input int x, input int y);
        return GRID * y + x;
    endfunction

endpackage

// File: rtl/inverse_permutation_function.sv
// rtl/inverse_permutation_function.sv - one combinational inverse lane-permutation round
module inverse_permutation_function
    import permutation_inverse_pkg::*;
#(
    parameter int WIDTH = 25
) (
    input  logic [WIDTH-1:0] state_in,
    output logic [WIDTH-1:0] state_out
);

    // out[x][y] = in[y][2*(x-y) mod 5]; the +10 keeps the modulus operand non-negative.
    always_comb begin
        state_out = '0;
        for (int x = 0; x < GRID; x++) begin
            for (int y = 0; y < GRID; y++) begin
                state_out[lane_idx(x, y)] = state_in[lane_idx(y, (2 * (x - y) + 10) % GRID)];
            end
        end
    end

endmodule

// File: rtl/permutation_inverse.sv
// rtl/permutation_inverse.sv - multi-round inverse permutation engine with start/done handshake
module permutation_inverse
    import permutation_inverse_pkg::*;
#(
    parameter int WIDTH = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       rounds,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             done,
    output logic             valid,
    output logic [WIDTH-1:0] result
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [4:0]       rounds_q, rounds_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] round_out;
    logic [4:0]       rounds_sat;

    inverse_permutation_function #(.WIDTH(WIDTH)) u_round (
        .state_in  (data_q),
        .state_out (round_out)
    );

    // Clamp requested round count; one full period is MAX_ROUNDS.
    always_comb begin
        rounds_sat = (rounds > 5'(MAX_ROUNDS)) ? 5'(MAX_ROUNDS) : rounds;
    end

    // Next-state, datapath and round counter control.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        rounds_d = rounds_q;
        valid_d  = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    data_d   = data_in;
                    rounds_d = rounds_sat;
                    cnt_d    = 5'd0;
                    valid_d  = 1'b0;
                    state_d  = (rounds_sat == 5'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                data_d = round_out;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == rounds_q - 5'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset aborts any run without a done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            cnt_q    <= 5'd0;
            rounds_q <= 5'd0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            rounds_q <= rounds_d;
            valid_q  <= valid_d;
        end
    end

    // Handshake outputs decoded from the state; valid also covers the done cycle.
    always_comb begin
        ready  = (state_q == ST_IDLE);
        done   = (state_q == ST_DONE);
        valid  = valid_q | (state_q == ST_DONE);
        result = data_q;
    end

endmodule

// File: tb/tb_permutation_inverse.sv
// tb/tb_permutation_inverse.sv - scoreboard bench for permutation_inverse
module tb_permutation_inverse;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  rounds = 5'd0;
    logic [24:0] data_in = 25'd0;
    logic        ready;
    logic        done;
    logic        valid;
    logic [24:0] result;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [24:0] res;
        int          done_edge;
    } exp_t;

    exp_t sb[$];

    permutation_inverse #(.WIDTH(25)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .rounds  (rounds),
        .data_in (data_in),
        .ready   (ready),
        .done    (done),
        .valid   (valid),
        .result  (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Forward rule: out[x][y] = in[(x+3y) mod 5][x].
    function automatic logic [24:0] fwd(input logic [24:0] v);
        logic [24:0] o;
        o = '0;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                o[5 * y + x] = v[5 * x + ((x + 3 * y) % 5)];
        return o;
    endfunction

    function automatic logic [24:0] fwd_n(input logic [24:0] v, input int n);
        logic [24:0] t;
        t = v;
        for (int i = 0; i < n; i++) t = fwd(t);
        return t;
    endfunction

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("result", 32'(result), 32'(e.res));
                chk("done_latency_edge", 32'(cyc), 32'(e.done_edge));
                chk("valid_at_done", 32'(valid), 32'd1);
                chk("ready_at_done", 32'(ready), 32'd0);
            end
        end
    end

    task automatic issue_start(input logic [24:0] d, input logic [4:0] r);
        int n;
        n = 0;
        while (!ready && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ready) chk("ready_wait_timeout", 32'(ready), 32'd1);
        start   = 1'b1;
        data_in = d;
        rounds  = r;
        @(posedge clk);
        #1;
        start   = 1'b0;
        data_in = 25'($urandom);
        rounds  = 5'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            chk("done_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        chk("ready_after_done", 32'(ready), 32'd1);
        chk("valid_holds", 32'(valid), 32'd1);
    endtask

    task automatic run_check(input logic [24:0] d, input logic [4:0] r,
                             input logic [24:0] exp, input int lat);
        exp_t e;
        issue_start(d, r);
        e.res       = exp;
        e.done_edge = cyc + lat;
        sb.push_back(e);
        if (lat > 0) begin
            chk("valid_cleared_on_start", 32'(valid), 32'd0);
            chk("ready_low_in_run", 32'(ready), 32'd0);
        end
        drain();
    endtask

    initial begin
        exp_t e;
        logic [24:0] v;

        #1;
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single bit: lane (0,2) moves to lane (1,0).
        run_check(25'h0000400, 5'd1, 25'h0000002, 1);
        // Full period returns the input.
        run_check(25'h1ABCDEF, 5'd24, 25'h1ABCDEF, 24);
        // Zero rounds: pass-through, done right after start.
        run_check(25'h1234567, 5'd0, 25'h1234567, 0);
        // Saturation: 31 behaves as 24.
        run_check(25'h0DEAD01, 5'd31, 25'h0DEAD01, 24);
        // Lane (0,0) is a fixed point.
        run_check(25'h0000001, 5'd5, 25'h0000001, 5);
        run_check(25'h0000001, 5'd13, 25'h0000001, 13);

        // Round trip against the forward rule for every round count.
        v = 25'h0F0F0F5;
        for (int n = 1; n <= 24; n++) begin
            run_check(fwd_n(v, n), 5'(n), v, n);
        end
        run_check(fwd_n(25'h1555AAA, 3), 5'd3, 25'h1555AAA, 3);

        // Busy start is ignored.
        issue_start(25'h1ABCDEF, 5'd24);
        e.res       = 25'h1ABCDEF;
        e.done_edge = cyc + 24;
        sb.push_back(e);
        repeat (4) @(posedge clk);
        #1;
        start   = 1'b1;
        data_in = 25'h0000400;
        rounds  = 5'd1;
        chk("ready_low_busy", 32'(ready), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();

        // Reset mid-run aborts immediately with no done.
        issue_start(25'h1FFFFFF ^ 25'h0000001, 5'd24);
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_valid", 32'(valid), 32'd0);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_check(fwd_n(25'h0F0F0F5, 7), 5'd7, 25'h0F0F0F5, 7);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
